mul_seq_32: RTL and testbench
=============================

# mul_seq_32

Iterative 32x32 multiplier for the datapath's multi-cycle execute path. It takes two 32-bit operands on a start pulse, runs a shift-add sequence for 32 cycles and returns a registered 64-bit product with a one-cycle done pulse. `res_lo` feeds the downstream 32-bit zero-detect stage directly, and `res_hi`/`res_lo` feed the HI/LO write-back path.

## Interface
- `WIDTH`, default 32: operand width. The block is specified and verified at 32 only.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request; sampled only in IDLE.
- `sign_op`, in, 1: 1 = two's-complement multiply, 0 = unsigned; sampled with `start`.
- `A`, in, 32: multiplicand; sampled with `start`.
- `B`, in, 32: multiplier; sampled with `start`.
- `busy`, out, 1: high while an operation is in flight.
- `done`, out, 1: one-cycle pulse; `res_hi`/`res_lo` are valid from this cycle.
- `res_hi`, out, 32: product bits [63:32].
- `res_lo`, out, 32: product bits [31:0].

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - RUN: 32 iteration cycles.
  - FIN: sign correction and result write.
- IDLE, `start`=1: latch operands.
  - Magnitudes: |A| and |B| when `sign_op`=1 and the operand's MSB is 1, else the raw value.
  - `neg` = `sign_op` & (A[31] ^ B[31]).
  - Accumulator cleared, count = 0, go to RUN.
- RUN, each cycle:
  - If the multiplier LSB is 1, add the multiplicand to the upper 32 bits of the accumulator. The adder is 33 bits wide and keeps its carry.
  - Shift {carry, accumulator, multiplier} right by 1.
  - Increment count.
  - When count = 31 at the edge, go to FIN.
- FIN:
  - product = `neg` ? two's-complement negation (64-bit) of the magnitude product : magnitude product.
  - Register the product into `res_hi`/`res_lo`, set `done`=1, go to IDLE.
- Width rules:
  - The magnitude of 0x80000000 is 0x80000000, treated as unsigned 32-bit; no overflow.
  - Every 32x32 product fits in 64 bits, so there is no overflow flag.
- `res_hi`/`res_lo` hold their value until the next FIN. They never show intermediate accumulator values.
- `start` in RUN or FIN is ignored. Operands are not re-sampled.
- `start` during the `done` cycle is accepted, since the state is IDLE. This allows back-to-back operations.
- `A`, `B` and `sign_op` may change freely after the start edge.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state = IDLE; `busy`=0, `done`=0, `res_hi`=0, `res_lo`=0.
  - Internal accumulator, count and `neg` cleared.
  - Takes effect immediately, without a clock edge.
- Reset mid-operation: the operation is abandoned. No `done` is produced and results stay 0.
- After `rst_n` deasserts, the first rising edge can accept `start`.
- Edge E0: `start` sampled in IDLE. From E0, `busy`=1.
- Edges E1..E32: iterations. E32 enters FIN.
- Edge E33: results written; `done`=1 and `busy`=0 from E33 until E34.
- Latency: 33 cycles from the start edge to the `done` edge.
- Throughput: one operation per 34 cycles when `start` is held continuously high. The start edge coincides with the edge after `done` (E34 of the previous operation).
- `done` is never high for two consecutive cycles.
- `busy` and `done` are never high together.

## Test plan
- Unsigned, `sign_op`=0, A=3, B=5 -> `res_hi`=0x00000000, `res_lo`=0x0000000F. `done` exactly 33 edges after start; `busy` high for 33 cycles.
- Unsigned, A=B=0xFFFFFFFF -> `res_hi`=0xFFFFFFFE, `res_lo`=0x00000001. Checks that the adder carry is kept.
- A=0xFFFFFFFF, B=7, run twice:
  - `sign_op`=1 -> `res_hi`=0xFFFFFFFF, `res_lo`=0xFFFFFFF9.
  - `sign_op`=0 -> `res_hi`=0x00000006, `res_lo`=0xFFFFFFF9.
- Signed, A=B=0x80000000 -> `res_hi`=0x40000000, `res_lo`=0. Then signed A=0x80000000, B=1 -> `res_hi`=0xFFFFFFFF, `res_lo`=0x80000000.
- Start while busy, and a zero operand:
  - Start A=0, B=0x12345678; pulse `start` again at E10 with A=B=2 -> `done` only once, at E33, with `res_hi`=`res_lo`=0. Downstream zero-detect output = 1.
  - Then hold `start`=1 across `done` with A=B=2 -> the next operation starts at E34; `res_lo`=4 at E67.
- Reset mid-operation: `rst_n` low for 1 cycle at iteration 10 of A=B=0x10000 -> outputs 0 immediately; no `done` afterwards. A new start then gives `res_hi`=1, `res_lo`=0 after 33 cycles.

Source files
------------

// File: rtl/mul_seq_32.sv
// Iterative shift-add multiplier: 32 iterations plus a sign-correction cycle,
// registered 2*WIDTH-bit product with a one-cycle done pulse.
module mul_seq_32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   mcand, mplier, acc;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod, prod_fin;

  // Negating the most-negative value wraps to itself, which read as unsigned is its magnitude.
  assign mag_a = (sign_op && A[WIDTH-1]) ? -A : A;
  assign mag_b = (sign_op && B[WIDTH-1]) ? -B : B;

  // The adder carry becomes the MSB of the accumulator after the right shift.
  assign sum      = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : '0)};
  assign prod     = {acc, mplier};
  assign prod_fin = neg ? -prod : prod;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            neg    <= sign_op & (A[WIDTH-1] ^ B[WIDTH-1]);
          end
        end
        RUN: begin
          acc    <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
        end
        FIN: begin
          res_hi <= prod_fin[2*WIDTH-1:WIDTH];
          res_lo <= prod_fin[WIDTH-1:0];
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_32.sv
// Scoreboard bench for mul_seq_32: stimulus pushes expected product and done
// cycle; a monitor pops and compares on every done pulse.
module tb_mul_seq_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sign_op = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done;
  logic [31:0] res_hi, res_lo;

  mul_seq_32 #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign_op(sign_op),
    .A(A), .B(B), .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] p;
    int unsigned c;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic        prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on sign- or zero-extended operands.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] xa, xb;
    xa = s ? {{32{a[31]}}, a} : {32'd0, a};
    xb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return xa * xb;
  endfunction

  // Monitor: product and latency on done, plus per-cycle handshake invariants.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done <= 1'b0;
    end else begin
      check("busy_and_done", {63'd0, busy & done}, 64'd0);
      check("done_twice", {63'd0, done & prev_done}, 64'd0);
      prev_done <= done;
      if (done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("product", {res_hi, res_lo}, e.p);
          check("done_cycle", 64'(cyc), 64'(e.c));
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit push, input logic [63:0] exp);
    exp_t e;
    @(negedge clk);
    start = 1'b1; A = a; B = b; sign_op = s;
    @(posedge clk); #1;
    if (push) begin
      e.p = exp;
      e.c = cyc + 33;
      sbq.push_back(e);
    end
    start = 1'b0; A = $urandom; B = $urandom; sign_op = 1'($urandom);
  endtask

  task automatic wait_done(output int bc);
    bit seen;
    bc = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) bc++;
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [63:0] exp);
    int bc;
    issue(a, b, s, 1, exp);
    wait_done(bc);
    check("busy_cycles", 64'(bc), 64'd33);
  endtask

  initial begin
    int bc;
    logic [31:0] ra, rb;
    logic        rs;
    logic [31:0] corner [6];
    corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000001};

    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_res", {res_hi, res_lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    op(32'd3, 32'd5, 1'b0, 64'h0000000F);
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
    op(32'hFFFFFFFF, 32'd7, 1'b1, 64'hFFFFFFFF_FFFFFFF9);
    op(32'hFFFFFFFF, 32'd7, 1'b0, 64'h00000006_FFFFFFF9);
    op(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
    op(32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF_80000000);

    // Start retriggered mid-operation must be ignored.
    issue(32'd0, 32'h12345678, 1'b0, 1, 64'd0);
    repeat (10) @(negedge clk);
    start = 1'b1; A = 32'd2; B = 32'd2; sign_op = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    wait_done(bc);
    check("zero_detect", {63'd0, res_lo == 32'd0}, 64'd1);

    // Start held through the done cycle is accepted on the following edge.
    begin
      exp_t e;
      start = 1'b1; A = 32'd2; B = 32'd2; sign_op = 1'b0;
      e.p = 64'd4;
      e.c = cyc + 34;
      sbq.push_back(e);
      @(posedge clk); #1; start = 1'b0;
      wait_done(bc);
      check("b2b_busy_cycles", 64'(bc), 64'd33);
    end

    // Reset in the middle of an operation abandons it.
    issue(32'h10000, 32'h10000, 1'b0, 0, 64'd0);
    repeat (10) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_res", {res_hi, res_lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_res_held", {res_hi, res_lo}, 64'd0);
    op(32'h10000, 32'h10000, 1'b1, 64'h00000001_00000000);

    for (int i = 0; i < 24; i++) begin
      ra = (i % 4 == 0) ? corner[$urandom_range(5)] : $urandom;
      rb = (i % 3 == 0) ? corner[$urandom_range(5)] : $urandom;
      rs = 1'($urandom);
      op(ra, rb, rs, ref_mul(ra, rb, rs));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
